// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the FPU datapath (divider and multiplier).
// Provides the FP32 field widths, exponent bias and limits, the canonical
// NaN encodings, the divider FSM state type and a packed FP32 struct.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;   // mantissa including hidden one

    localparam int                BIAS     = 127;
    localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
    localparam logic [31:0]       QNAN     = 32'h7FC0_0000;
    localparam logic [31:0]       QNAN_NEG = 32'hFFC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Signed infinity / signed zero builders.
    function automatic fp32_t fp_inf(input logic s);
        return '{sign: s, exp: EXP_MAX, frac: '0};
    endfunction

    function automatic fp32_t fp_zero(input logic s);
        return '{sign: s, exp: '0, frac: '0};
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// Combinational FP32 operand classifier.
// Ports:
//   x_i       FP32 operand
//   is_nan_o  exponent all ones, fraction nonzero
//   is_inf_o  exponent all ones, fraction zero
//   is_zero_o exponent zero (denormals are flushed and count as zero)
//   is_norm_o ordinary normal number
module fpu_classify
    import fpu_pkg::*;
(
    input  logic [31:0] x_i,
    output logic        is_nan_o,
    output logic        is_inf_o,
    output logic        is_zero_o,
    output logic        is_norm_o
);

    fp32_t f;
    logic  exp_max, exp_zero, frac_zero;

    assign f         = fp32_t'(x_i);
    assign exp_max   = (f.exp == EXP_MAX);
    assign exp_zero  = (f.exp == '0);
    assign frac_zero = (f.frac == '0);

    assign is_nan_o  = exp_max & ~frac_zero;
    assign is_inf_o  = exp_max & frac_zero;
    assign is_zero_o = exp_zero;
    assign is_norm_o = ~exp_max & ~exp_zero;

endmodule

// File: rtl/fpu_divider.sv
// Sequential FP32 divider: op = a / b, radix-2 restoring mantissa division,
// one quotient bit per cycle, truncating rounding, denormals flushed to zero.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only when idle)
//   a, b                  dividend / divisor, FP32
//   out_valid / out_ready result handshake (result held until taken)
//   op                    quotient, FP32, stable while out_valid
module fpu_divider
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op
);

    // ---------------------------------------------------------------
    // Operand classification (on the live inputs, used at capture)
    // ---------------------------------------------------------------
    fp32_t fa, fb;
    logic  a_nan, a_inf, a_zero, a_norm;
    logic  b_nan, b_inf, b_zero, b_norm;

    assign fa = fp32_t'(a);
    assign fb = fp32_t'(b);

    fpu_classify u_cls_a (
        .x_i      (a),
        .is_nan_o (a_nan),
        .is_inf_o (a_inf),
        .is_zero_o(a_zero),
        .is_norm_o(a_norm)
    );

    fpu_classify u_cls_b (
        .x_i      (b),
        .is_nan_o (b_nan),
        .is_inf_o (b_inf),
        .is_zero_o(b_zero),
        .is_norm_o(b_norm)
    );

    logic  sign_in;
    logic  special_in;
    fp32_t special_res;

    assign sign_in    = fa.sign ^ fb.sign;
    assign special_in = ~(a_norm & b_norm);

    // Priority chain for non-normal operand pairs.
    always_comb begin
        special_res = fp_zero(sign_in);
        if (a_nan | b_nan)
            special_res = fp32_t'(QNAN);
        else if ((a_zero & b_zero) | (a_inf & b_inf))
            special_res = fp32_t'(QNAN_NEG);
        else if (a_inf)
            special_res = fp_inf(sign_in);
        else if (b_zero)
            special_res = fp_inf(sign_in);
        else
            special_res = fp_zero(sign_in);
    end

    // ---------------------------------------------------------------
    // Registered state
    // ---------------------------------------------------------------
    state_e              state_q;
    logic                sign_q;
    logic [EXP_W-1:0]    ea_q, eb_q;
    logic [MANT_W-1:0]   mb_q;
    logic [MANT_W:0]     rem_q, rem_d;
    logic [MANT_W:0]     q_q, q_d;
    logic [4:0]          count_q;
    logic [31:0]         op_q;
    logic                out_valid_q;
    logic                in_ready_q;

    // ---------------------------------------------------------------
    // One restoring-division step
    // ---------------------------------------------------------------
    logic            rem_ge;
    logic [MANT_W:0] rem_sub;

    always_comb begin
        rem_ge  = (rem_q >= {1'b0, mb_q});
        rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        // rem_sub < mb after a restore step, so the top bit is always zero.
        rem_d   = {rem_sub[MANT_W-1:0], 1'b0};
        q_d     = {q_q[MANT_W-1:0], rem_ge};
    end

    // ---------------------------------------------------------------
    // Normalisation and exponent range check
    // ---------------------------------------------------------------
    logic              adj;
    logic [FRAC_W-1:0] frac_n;
    logic signed [9:0] e_n;
    fp32_t             norm_res;

    always_comb begin
        // Quotient of two [1,2) mantissas lies in (0.5,2); q[24] is the 2^0 bit.
        adj    = ~q_q[MANT_W];
        frac_n = q_q[MANT_W] ? q_q[MANT_W-1:1] : q_q[FRAC_W-1:0];
        // 10-bit wraparound arithmetic, read back as signed.
        e_n    = $signed({2'b00, ea_q} - {2'b00, eb_q} + 10'(BIAS) - {9'd0, adj});
        if (e_n >= 10'sd255)
            norm_res = fp_inf(sign_q);
        else if (e_n <= 10'sd0)
            norm_res = fp_zero(sign_q);
        else
            norm_res = '{sign: sign_q, exp: e_n[EXP_W-1:0], frac: frac_n};
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            mb_q        <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            count_q     <= '0;
            op_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= sign_in;
                        ea_q       <= fa.exp;
                        eb_q       <= fb.exp;
                        mb_q       <= {1'b1, fb.frac};
                        rem_q      <= {2'b01, fa.frac};
                        q_q        <= '0;
                        count_q    <= '0;
                        if (special_in) begin
                            op_q        <= special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q     <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem_q   <= rem_d;
                    q_q     <= q_d;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd24)
                        state_q <= NORM;
                end
                NORM: begin
                    op_q        <= norm_res;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign op        = op_q;

endmodule

// File: tb/tb_fpu_divider.sv
// Self-checking bench for fpu_divider: directed operand pairs with literal
// expectations, plus a cycle-by-cycle monitor against a plain-arithmetic model.
module tb_fpu_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] op;

    fpu_divider dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .op       (op)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: quotient straight from the IEEE rules with integer division.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        longint      mx, my, q;
        bit          nx, ny, ix, iy, zx, zy;
        logic [22:0] f;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && !nx;
        iy = (ey == 255) && !ny;
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny) return 32'h7FC00000;
        if ((zx && zy) || (ix && iy)) return 32'hFFC00000;
        if (ix || zy) return {s, 8'hFF, 23'd0};
        if (zx || iy) return {s, 31'd0};
        mx = longint'({1'b1, x[22:0]});
        my = longint'({1'b1, y[22:0]});
        q  = (mx << 24) / my;          // truncated quotient, 2^0 at bit 24
        e  = ex - ey + 127;
        if (q >= 64'sd16777216) begin
            f = 23'((q >> 1) & 64'h7FFFFF);
        end else begin
            f = 23'(q & 64'h7FFFFF);
            e = e - 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), f};
    endfunction

    function automatic int model_lat(input logic [31:0] x, input logic [31:0] y);
        if (x[30:23] == 8'h00 || x[30:23] == 8'hFF || y[30:23] == 8'h00 || y[30:23] == 8'hFF)
            return 1;
        return 27;
    endfunction

    // ---------------- monitor ----------------
    bit          mon_en = 1'b0;
    bit          busy   = 1'b0;
    int          acc_cyc;
    int          exp_lat;
    logic [31:0] exp_op;
    logic        ev;

    always @(negedge clk) begin
        if (mon_en) begin
            ev = busy && (cyc - acc_cyc >= exp_lat);
            chk("mon_out_valid", {31'd0, out_valid}, {31'd0, ev});
            chk("mon_in_ready", {31'd0, in_ready}, {31'd0, !busy});
            if (out_valid && busy)
                chk("mon_op", op, exp_op);
            if (rst)
                busy = 1'b0;
            else if (busy && out_valid && out_ready)
                busy = 1'b0;
            else if (!busy && in_valid && in_ready) begin
                busy    = 1'b1;
                acc_cyc = cyc;
                exp_op  = model(a, b);
                exp_lat = model_lat(a, b);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic wait_accept(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in_ready && k < 100);
        if (!in_ready) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #2;
    endtask

    // Returns number of cycles from acceptance until out_valid seen.
    task automatic wait_result(input string name, output int lat, output bit ok);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 60);
        lat = k;
        ok  = out_valid;
        if (!ok) chk({name, "_result_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat_exp, input string name);
        int lat;
        bit ok;
        @(posedge clk);
        #2;
        a = x; b = y; in_valid = 1'b1;
        wait_accept(name);
        in_valid = 1'b0;
        a = $urandom; b = $urandom;     // operands must have been registered
        wait_result(name, lat, ok);
        if (ok) begin
            chk({name, "_lat"}, 32'(lat), 32'(lat_exp));
            chk({name, "_op"}, op, exp);
        end
        @(posedge clk);                 // handshake edge (out_ready high)
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] held;
    bit          seen;
    int          lat;
    bit          ok;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;

        // Model pins
        chk("model_6div2", model(32'h40C00000, 32'h40000000), 32'h40400000);
        chk("model_1div3", model(32'h3F800000, 32'h40400000), 32'h3EAAAAAA);
        chk("model_ovf",   model(32'h7F000000, 32'h3E800000), 32'h7F800000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_op",        op,                 32'h00000000);
        mon_en = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;

        run(32'h40C00000, 32'h40000000, 32'h40400000, 27, "div_6_2");
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, "div_1_3");
        run(32'hBF800000, 32'h40400000, 32'hBEAAAAAA, 27, "div_m1_3");
        run(32'h40E00000, 32'h40000000, 32'h40600000, 27, "div_7_2");
        run(32'h3F800000, 32'h3F800000, 32'h3F800000, 27, "div_1_1");
        run(32'hBF800000, 32'h00000000, 32'hFF800000, 1,  "sp_m1_0");
        run(32'h00000000, 32'h00000000, 32'hFFC00000, 1,  "sp_0_0");
        run(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1,  "sp_nan");
        run(32'h7F800000, 32'hFF800000, 32'hFFC00000, 1,  "sp_inf_inf");
        run(32'h7F800000, 32'hC0000000, 32'hFF800000, 1,  "sp_inf_m2");
        run(32'h3F800000, 32'h7F800000, 32'h00000000, 1,  "sp_1_inf");
        run(32'h80000000, 32'h40A00000, 32'h80000000, 1,  "sp_m0_5");
        run(32'h7F000000, 32'h3E800000, 32'h7F800000, 27, "ovf");
        run(32'h00800000, 32'h40000000, 32'h00000000, 27, "unf");
        run(32'h00000001, 32'h3F800000, 32'h00000000, 1,  "denorm");

        // Backpressure: result held while the next operand waits.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        wait_accept("bp");
        a = 32'h40E00000; b = 32'h40000000;    // next operand, kept valid
        wait_result("bp", lat, ok);
        held = op;
        chk("bp_first_op", op, 32'h40400000);
        repeat (10) begin
            @(negedge clk);
            chk("bp_op_stable", op, held);
            chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_cycle_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);                          // second operand accepted here
        #2 in_valid = 1'b0;
        wait_result("bp2", lat, ok);
        if (ok) begin
            chk("bp2_lat", 32'(lat), 32'd27);
            chk("bp2_op", op, 32'h40600000);
        end
        @(posedge clk);

        // Reset in the middle of a normal divide.
        @(posedge clk);
        #2;
        a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
        wait_accept("rst_mid");
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        seen = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_mid_no_output", {31'd0, seen}, 32'd0);
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 27, "after_rst");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fpu_divider.md
# fpu_divider

Sequential IEEE-754 single-precision divider, the inverse companion to the combinational FP32 multiplier in the FPU datapath. It computes a/b with a radix-2 restoring mantissa divider, one quotient bit per cycle. It follows the multiplier's special-value, truncation and flush conventions. A valid/ready handshake on each side lets the FPU issue logic stall on it.

## Interface
- Parameters: none (FP32 format fixed).
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  divider can accept; high only in IDLE.
- a  input  32  dividend, FP32.
- b  input  32  divisor, FP32.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- op  output  32  quotient, FP32; stable while out_valid.

## Operation
- Fields: {sign, exp[7:0], frac[22:0]}. Result sign = sa ^ sb for every case except canonical NaNs.
- Denormal input (exp=0, frac≠0) is treated as signed zero (flush).
- Special cases are checked in priority order:
  - either input NaN -> 0x7FC00000;
  - 0/0 or inf/inf -> 0xFFC00000;
  - a inf (b finite) -> signed inf;
  - b zero (a nonzero finite) -> signed inf;
  - a zero or b inf -> signed zero.
- Normal path:
  - ma = {1,frac_a}, mb = {1,frac_b}, each 24 bits. The remainder register is 25 bits and starts as ma.
  - Each of 25 iterations: if rem ≥ mb, the quotient bit is 1 and rem -= mb; otherwise the bit is 0. Then rem <<= 1. Bits fill q[24:0] MSB first.
  - If q[24]=1: frac = q[23:1] and adj = 0. Otherwise frac = q[22:0] and adj = 1.
  - Exponent is computed in a 10-bit signed register: e = Ea − Eb + 127 − adj.
  - e ≥ 255 -> signed inf (frac 0). e ≤ 0 -> signed zero.
  - Rounding is truncation; the remainder is discarded.
- FSM:
  - IDLE: in_ready=1. On in_valid, capture operands and classify. A special case goes to DONE with op loaded. Otherwise go to DIV with count=0.
  - DIV: one iteration per cycle. At count=24, go to NORM.
  - NORM: normalize, check exponent range, load op, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- One operation in flight. The divider does not accept a new operand in the same cycle a result is taken.

## Timing
- Reset values:
  - state = IDLE;
  - out_valid = 0;
  - op = 0x00000000;
  - in_ready = 1 from the first cycle after reset;
  - count, q and rem cleared.
- Acceptance happens at the edge where in_valid && in_ready.
- Normal operands: DIV occupies cycles 1–25, NORM is cycle 26, and out_valid rises in cycle 27 (latency 27).
- Special operands: out_valid is high in cycle 1 (latency 1).
- Back-to-back throughput:
  - normal operands: one result per 28 cycles;
  - special operands: one result per 2 cycles;
  - in both cases only if out_ready is held high.
- Backpressure: while out_valid && !out_ready, op and out_valid hold indefinitely and in_ready stays 0.
- a/b changing after acceptance has no effect; the operands are registered.
- rst mid-operation (any state) aborts the operation:
  - the next cycle is IDLE with out_valid = 0;
  - the in-flight result is lost, with no partial output.
- rst takes priority over a simultaneous in_valid or out_ready.

## Structure
- Package fpu_pkg:
  - FP32 field widths;
  - BIAS = 127;
  - EXP_MAX = 8'hFF;
  - QNAN = 32'h7FC00000;
  - QNAN_NEG = 32'hFFC00000;
  - the FSM state enum {IDLE, DIV, NORM, DONE};
  - fp32 packed struct typedef.
- Sub-module fpu_classify: combinational, 32-bit input. Outputs is_nan, is_inf, is_zero (including denormal flush) and is_norm. It is instantiated once per operand; the multiplier shares it.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> op=0x40400000, out_valid exactly 27 cycles after acceptance.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- Specials:
  - 0xBF800000 / 0x00000000 -> 0xFF800000;
  - 0/0 -> 0xFFC00000;
  - 0x7FC00001 / 1.0 -> 0x7FC00000;
  - each with latency 1.
- Range:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000 (overflow);
  - 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush);
  - denormal 0x00000001 / 1.0 -> 0x00000000.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1. op stays stable and in_ready stays 0. Release, and the next operand is accepted no earlier than the cycle after the handshake.
- Assert rst at cycle 12 of a normal divide -> out_valid stays 0. The next division returns the correct value with nominal latency.
